// File: rtl/weyl_sng_if.sv
// Sample-in / bitstream-out bundle for weyl_sng.
// Optional macro WEYL_SNG_COUNT_EN adds the count_out signal.
interface weyl_sng_if #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) ();
  // valid_in qualifies data for one cycle; there is no ready, the sink always accepts.
  // valid_out pulses one cycle after an accepted sample, while quota holds otherwise.
  logic                 valid_in;
  logic [QUANT-1:0]     data;
  logic                 valid_out;
  logic [BITSTREAM-1:0] quota;
`ifdef WEYL_SNG_COUNT_EN
  logic [$clog2(BITSTREAM+1)-1:0] count_out;
`endif

  modport master (
    output valid_in,
    output data,
    input  valid_out,
    input  quota
`ifdef WEYL_SNG_COUNT_EN
    , input count_out
`endif
  );

  modport slave (
    input  valid_in,
    input  data,
    output valid_out,
    output quota
`ifdef WEYL_SNG_COUNT_EN
    , output count_out
`endif
  );
endinterface

// File: rtl/weyl_sng.sv
// Stochastic number generator: signed sample -> quota of ones spread on a Weyl sequence.
// Optional macro WEYL_SNG_COUNT_EN registers the quota count s on count_out.
module weyl_sng #(
  parameter int BITSTREAM = 64,
  parameter int BASE      = 2,
  parameter int STRIDE    = 17,
  parameter int QUANT     = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  weyl_sng_if.slave bus
);
  localparam int CW = $clog2(BITSTREAM + 1);
  localparam int UW = QUANT + $clog2(BITSTREAM) + 2;

  localparam logic [QUANT-1:0] MIN_CODE = {1'b1, {(QUANT-1){1'b0}}};
  localparam logic [UW-1:0]    FULL     = UW'(1) << QUANT;
  localparam logic [UW-1:0]    HALF     = UW'(1) << (QUANT - 1);
  localparam logic [UW-1:0]    SCALE    = UW'(BITSTREAM);

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // rank[j] = k such that (BASE + k*STRIDE) mod BITSTREAM == j; a bijection because STRIDE is coprime.
  function automatic logic [BITSTREAM-1:0][CW-1:0] build_rank();
    logic [BITSTREAM-1:0][CW-1:0] r;
    r = '0;
    for (int k = 0; k < BITSTREAM; k++) begin
      r[(BASE + k * STRIDE) % BITSTREAM] = CW'(k);
    end
    return r;
  endfunction

  localparam logic [BITSTREAM-1:0][CW-1:0] RANK = build_rank();

  if (gcd(STRIDE, BITSTREAM) != 1) begin : g_bad_stride
    $fatal(1, "weyl_sng: STRIDE must be coprime with BITSTREAM");
  end
  if (BASE >= BITSTREAM) begin : g_bad_base
    $fatal(1, "weyl_sng: BASE must be below BITSTREAM");
  end
  if (QUANT < 2) begin : g_bad_quant
    $fatal(1, "weyl_sng: QUANT must be at least 2");
  end
  if (BITSTREAM < 2) begin : g_bad_width
    $fatal(1, "weyl_sng: BITSTREAM must be at least 2");
  end

  logic [UW-1:0]        u;
  logic [UW-1:0]        scaled;
  logic [UW-1:0]        s_raw;
  logic [CW-1:0]        s;
  logic [BITSTREAM-1:0] word;

  // Adding 2^(QUANT-1) to a two's-complement value is an MSB flip; the reserved code means full scale.
  always_comb begin
    u = '0;
    if (bus.data == MIN_CODE) begin
      u = FULL;
    end else begin
      u = UW'({~bus.data[QUANT-1], bus.data[QUANT-2:0]});
    end
    scaled = u * SCALE + HALF;
    s_raw  = scaled >> QUANT;
    s      = (s_raw > SCALE) ? CW'(BITSTREAM) : s_raw[CW-1:0];
  end

  always_comb begin
    word = '0;
    for (int j = 0; j < BITSTREAM; j++) begin
      word[j] = (RANK[j] < s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.quota     <= '0;
      bus.valid_out <= 1'b0;
`ifdef WEYL_SNG_COUNT_EN
      bus.count_out <= '0;
`endif
    end else begin
      bus.valid_out <= bus.valid_in;
      if (bus.valid_in) begin
        bus.quota <= word;
`ifdef WEYL_SNG_COUNT_EN
        bus.count_out <= s;
`endif
      end
    end
  end
endmodule

// File: tb/tb_weyl_sng.sv
// Bench for weyl_sng: vector table, reset/hold sequences and a full-code sweep
// checked against an independent Weyl-placement model through an expected queue.
module tb_weyl_sng;
  localparam int BITSTREAM = 64;
  localparam int BASE      = 2;
  localparam int STRIDE    = 17;
  localparam int QUANT     = 8;

  logic clk;
  logic rst_n;

  weyl_sng_if #(.BITSTREAM(BITSTREAM), .QUANT(QUANT)) bus ();

  weyl_sng #(
    .BITSTREAM(BITSTREAM),
    .BASE(BASE),
    .STRIDE(STRIDE),
    .QUANT(QUANT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [BITSTREAM-1:0] exp_q[$];
  int                   exp_s_q[$];
  logic [BITSTREAM-1:0] hold_word;
  int                   n_checks;
  int                   n_fail;

  typedef struct {
    logic [QUANT-1:0]     d;
    logic [BITSTREAM-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic int model_s(input logic [QUANT-1:0] d);
    int u;
    int s;
    if (d == 8'h80) u = 256;
    else u = int'($signed(d)) + 128;
    s = (u * BITSTREAM + 128) / 256;
    if (s > BITSTREAM) s = BITSTREAM;
    return s;
  endfunction

  function automatic logic [BITSTREAM-1:0] model_word(input int s);
    logic [BITSTREAM-1:0] w;
    w = '0;
    for (int k = 0; k < s; k++) w[(BASE + k * STRIDE) % BITSTREAM] = 1'b1;
    return w;
  endfunction

  task automatic check(input string name, input logic [BITSTREAM-1:0] act,
                       input logic [BITSTREAM-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present one cycle of input, then check what the DUT produced after the edge
  task automatic apply(input logic v, input logic [QUANT-1:0] d);
    logic [BITSTREAM-1:0] e;
    int                   es;
    bus.valid_in = v;
    bus.data     = d;
    if (v) begin
      es = model_s(d);
      exp_q.push_back(model_word(es));
      exp_s_q.push_back(es);
    end
    @(posedge clk);
    #1;
    check("valid_out", 64'(bus.valid_out), 64'(v));
    if (bus.valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got output with empty expected queue");
      end else begin
        e  = exp_q.pop_front();
        es = exp_s_q.pop_front();
        check("quota", bus.quota, e);
        check("popcount", 64'($countones(bus.quota)), 64'(es));
`ifdef WEYL_SNG_COUNT_EN
        check("count_out", 64'(bus.count_out), 64'(es));
`endif
        hold_word = e;
      end
    end else begin
      check("hold", bus.quota, hold_word);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    hold_word    = '0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data     = '0;

    vecs[0] = '{8'h81, 64'h0};                    // -127
    vecs[1] = '{8'h82, 64'h4};                    // -126
    vecs[2] = '{8'h83, 64'h4};                    // -125
    vecs[3] = '{8'h84, 64'h4};                    // -124
    vecs[4] = '{8'h85, 64'h4};                    // -123
    vecs[5] = '{8'h86, 64'h0000_0000_0008_0004};  // -122, s = 2
    vecs[6] = '{8'h7F, {BITSTREAM{1'b1}}};        // +127
    vecs[7] = '{8'h80, {BITSTREAM{1'b1}}};        // reserved code

    repeat (3) @(posedge clk);
    #1;
    check("reset_quota", bus.quota, '0);
    check("reset_valid", 64'(bus.valid_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      apply(1'b1, vecs[i].d);
      check($sformatf("table_%0d", i), bus.quota, vecs[i].exp);
    end

    // mid-stream asynchronous reset, sampled between clock edges
    apply(1'b1, 8'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_quota", bus.quota, '0);
    check("async_rst_valid", 64'(bus.valid_out), 64'd0);
    exp_q.delete();
    exp_s_q.delete();
    hold_word = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply(1'b1, 8'h00);
    check("zero_pop32", 64'($countones(bus.quota)), 64'd32);
    check("zero_bits", 64'({bus.quota[2], bus.quota[19], bus.quota[36],
                             bus.quota[53], bus.quota[6]}), 64'h1F);

    for (int i = 0; i < 3; i++) apply(1'b0, 8'($urandom_range(0, 255)));

    for (int d = -127; d <= 127; d++) begin
      apply(1'b1, 8'(d));
      if ($urandom_range(0, 3) == 0) apply(1'b0, 8'($urandom_range(0, 255)));
    end
    apply(1'b1, 8'h80);
    apply(1'b0, 8'h00);

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
